// File: rtl/sulba_pkg.sv
// sulba_pkg: shared widths, state encoding and geometry typedefs for the Sulba vertex path
package sulba_pkg;
    localparam int FIXED_POINT = 8;
    localparam int DEF_COORD_WIDTH = 16;

    function automatic int area_width(input int cw);
        return 2 * cw + 4;
    endfunction

    localparam int AREA_WIDTH = area_width(DEF_COORD_WIDTH);

    typedef enum logic [1:0] {COLLECT, CLOSE, RESULT} state_e;
    typedef logic [DEF_COORD_WIDTH-1:0] coord_t;
    typedef logic signed [AREA_WIDTH-1:0] area_t;
endpackage

// File: rtl/sulba_cross_term.sv
// sulba_cross_term: signed shoelace term a.x*b.y - b.x*a.y on zero-extended unsigned coordinates
module sulba_cross_term #(
    parameter int COORD_WIDTH = 16,
    parameter int AREA_WIDTH = 36
) (
    input  logic [COORD_WIDTH-1:0]       ax,
    input  logic [COORD_WIDTH-1:0]       ay,
    input  logic [COORD_WIDTH-1:0]       bx,
    input  logic [COORD_WIDTH-1:0]       by,
    output logic signed [AREA_WIDTH-1:0] term
);
    logic [AREA_WIDTH-1:0] p, q;

    assign p = AREA_WIDTH'(ax) * AREA_WIDTH'(by);
    assign q = AREA_WIDTH'(bx) * AREA_WIDTH'(ay);
    assign term = signed'(p - q);
endmodule

// File: rtl/sulba_vertex_collector.sv
// sulba_vertex_collector: accumulates a polygon outline into twice-area, orientation, bbox and vertex count
module sulba_vertex_collector import sulba_pkg::*; #(
    parameter int COORD_WIDTH = DEF_COORD_WIDTH,
    parameter int MAX_VERTS = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    input  logic [COORD_WIDTH-1:0]              in_x,
    input  logic [COORD_WIDTH-1:0]              in_y,
    input  logic                                in_last,
    output logic                                in_ready,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [2*COORD_WIDTH+3:0]            out_area2,
    output logic                                out_cw,
    output logic [COORD_WIDTH-1:0]              out_min_x,
    output logic [COORD_WIDTH-1:0]              out_max_x,
    output logic [COORD_WIDTH-1:0]              out_min_y,
    output logic [COORD_WIDTH-1:0]              out_max_y,
    output logic [CNT_WIDTH-1:0]                out_count,
    output logic                                out_overflow,
    output logic                                busy
);
    localparam int AW = area_width(COORD_WIDTH);
    localparam logic [CNT_WIDTH-1:0] MAXC = CNT_WIDTH'(MAX_VERTS);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d, ocnt_q, ocnt_d;
    logic signed [AW-1:0]    acc_q, acc_d, term;
    logic [COORD_WIDTH-1:0]  v0x_q, v0x_d, v0y_q, v0y_d, px_q, px_d, py_q, py_d;
    logic [COORD_WIDTH-1:0]  minx_q, minx_d, maxx_q, maxx_d, miny_q, miny_d, maxy_q, maxy_d;
    logic [COORD_WIDTH-1:0]  ominx_q, ominx_d, omaxx_q, omaxx_d, ominy_q, ominy_d, omaxy_q, omaxy_d;
    logic [AW-1:0]           area_q, area_d;
    logic                    ovf_q, ovf_d, oovf_q, oovf_d, cw_q, cw_d;
    logic                    in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [COORD_WIDTH-1:0]  bx, by;

    // The single cross-term unit pairs prev with the incoming vertex, or with v0 to close the outline.
    assign bx = (state_q == CLOSE) ? v0x_q : in_x;
    assign by = (state_q == CLOSE) ? v0y_q : in_y;

    sulba_cross_term #(.COORD_WIDTH(COORD_WIDTH), .AREA_WIDTH(AW)) u_cross (
        .ax(px_q), .ay(py_q), .bx(bx), .by(by), .term(term)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d = acc_q;
        v0x_d = v0x_q;
        v0y_d = v0y_q;
        px_d = px_q;
        py_d = py_q;
        minx_d = minx_q;
        maxx_d = maxx_q;
        miny_d = miny_q;
        maxy_d = maxy_q;
        ovf_d = ovf_q;
        area_d = area_q;
        cw_d = cw_q;
        ominx_d = ominx_q;
        omaxx_d = omaxx_q;
        ominy_d = ominy_q;
        omaxy_d = omaxy_q;
        ocnt_d = ocnt_q;
        oovf_d = oovf_q;
        out_valid_d = out_valid_q;
        in_ready_d = 1'b0;
        case (state_q)
            COLLECT: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    if (count_q == '0) begin
                        v0x_d = in_x;
                        v0y_d = in_y;
                        px_d = in_x;
                        py_d = in_y;
                        minx_d = in_x;
                        maxx_d = in_x;
                        miny_d = in_y;
                        maxy_d = in_y;
                        count_d = CNT_WIDTH'(1);
                        acc_d = '0;
                    end else if (count_q < MAXC) begin
                        acc_d = acc_q + term;
                        minx_d = (in_x < minx_q) ? in_x : minx_q;
                        maxx_d = (in_x > maxx_q) ? in_x : maxx_q;
                        miny_d = (in_y < miny_q) ? in_y : miny_q;
                        maxy_d = (in_y > maxy_q) ? in_y : maxy_q;
                        px_d = in_x;
                        py_d = in_y;
                        count_d = count_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = CLOSE;
                        in_ready_d = 1'b0;
                    end
                end
            end
            CLOSE: begin
                acc_d = acc_q + term;
                state_d = RESULT;
            end
            RESULT: begin
                // First RESULT cycle publishes the record; later cycles wait for the handshake.
                if (!out_valid_q) begin
                    area_d = acc_q[AW-1] ? AW'(-acc_q) : AW'(acc_q);
                    cw_d = acc_q[AW-1];
                    ominx_d = minx_q;
                    omaxx_d = maxx_q;
                    ominy_d = miny_q;
                    omaxy_d = maxy_q;
                    ocnt_d = count_q;
                    oovf_d = ovf_q;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    count_d = '0;
                    acc_d = '0;
                    v0x_d = '0;
                    v0y_d = '0;
                    px_d = '0;
                    py_d = '0;
                    minx_d = '0;
                    maxx_d = '0;
                    miny_d = '0;
                    maxy_d = '0;
                    ovf_d = 1'b0;
                    state_d = COLLECT;
                    in_ready_d = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            count_q <= '0;
            acc_q <= '0;
            v0x_q <= '0;
            v0y_q <= '0;
            px_q <= '0;
            py_q <= '0;
            minx_q <= '0;
            maxx_q <= '0;
            miny_q <= '0;
            maxy_q <= '0;
            ovf_q <= 1'b0;
            area_q <= '0;
            cw_q <= 1'b0;
            ominx_q <= '0;
            omaxx_q <= '0;
            ominy_q <= '0;
            omaxy_q <= '0;
            ocnt_q <= '0;
            oovf_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q <= acc_d;
            v0x_q <= v0x_d;
            v0y_q <= v0y_d;
            px_q <= px_d;
            py_q <= py_d;
            minx_q <= minx_d;
            maxx_q <= maxx_d;
            miny_q <= miny_d;
            maxy_q <= maxy_d;
            ovf_q <= ovf_d;
            area_q <= area_d;
            cw_q <= cw_d;
            ominx_q <= ominx_d;
            omaxx_q <= omaxx_d;
            ominy_q <= ominy_d;
            omaxy_q <= omaxy_d;
            ocnt_q <= ocnt_d;
            oovf_q <= oovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_area2 = area_q;
    assign out_cw = cw_q;
    assign out_min_x = ominx_q;
    assign out_max_x = omaxx_q;
    assign out_min_y = ominy_q;
    assign out_max_y = omaxy_q;
    assign out_count = ocnt_q;
    assign out_overflow = oovf_q;
    assign busy = (count_q != '0) || (state_q != COLLECT);
endmodule

// File: tb/tb_sulba_vertex_collector.sv
// tb_sulba_vertex_collector: directed vectors with hand-computed shoelace results
module tb_sulba_vertex_collector;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_x = '0;
    logic [15:0] in_y = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [35:0] out_area2;
    logic        out_cw;
    logic [15:0] out_min_x, out_max_x, out_min_y, out_max_y;
    logic [3:0]  out_count;
    logic        out_overflow;
    logic        busy;
    int          n_chk = 0;
    int          n_pass = 0;

    sulba_vertex_collector dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_area2(out_area2), .out_cw(out_cw), .out_min_x(out_min_x), .out_max_x(out_max_x),
        .out_min_y(out_min_y), .out_max_y(out_max_y), .out_count(out_count),
        .out_overflow(out_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic put(input int x, input int y, input bit last);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("put_ready_timeout", in_ready, 1);
        in_valid = 1'b1;
        in_x = 16'(x);
        in_y = 16'(y);
        in_last = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic result(input string tag, input longint area, input bit cw, input int minx,
                          input int maxx, input int miny, input int maxy, input int cnt, input bit ovf);
        int n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_area"}, out_area2, area);
        chk({tag, "_cw"}, out_cw, cw);
        chk({tag, "_minx"}, out_min_x, minx);
        chk({tag, "_maxx"}, out_max_x, maxx);
        chk({tag, "_miny"}, out_min_y, miny);
        chk({tag, "_maxy"}, out_max_y, maxy);
        chk({tag, "_cnt"}, out_count, cnt);
        chk({tag, "_ovf"}, out_overflow, ovf);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drop"}, out_valid, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_area", out_area2, 0);
        chk("rst_cnt", out_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready_rise", in_ready, 1);

        put(0, 0, 0); put(256, 0, 0); put(256, 256, 0); put(0, 256, 1);
        chk("sq_busy", busy, 1);
        chk("sq_lat0", out_valid, 0);
        @(posedge clk);
        #1;
        chk("sq_lat1", out_valid, 0);
        chk("sq_close_rdy", in_ready, 0);
        @(posedge clk);
        #1;
        chk("sq_lat2", out_valid, 1);
        result("sq", 131072, 0, 0, 256, 0, 256, 4, 0);
        chk("sq_rdy_back", in_ready, 1);

        put(0, 0, 0); put(0, 256, 0); put(256, 256, 0); put(256, 0, 1);
        result("rev", 131072, 1, 0, 256, 0, 256, 4, 0);

        put(0, 0, 0); put(512, 0, 0); put(0, 256, 1);
        result("tri", 131072, 0, 0, 512, 0, 256, 3, 0);

        begin
            int vx[10] = '{0, 100, 200, 200, 200, 100, 0, 0, 500, 600};
            int vy[10] = '{0, 0, 0, 100, 200, 200, 200, 100, 500, 600};
            for (int i = 0; i < 10; i++) begin
                chk("ovf_rdy", in_ready, 1);
                put(vx[i], vy[i], i == 9);
            end
        end
        result("ovf", 80000, 0, 0, 200, 0, 200, 8, 1);

        put(5, 7, 0); put(9, 3, 1);
        result("two", 0, 0, 5, 9, 3, 7, 2, 0);

        put(0, 0, 0); put(100, 0, 0); put(0, 100, 1);
        begin
            int n = 0;
            while (!out_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_area", out_area2, 10000);
            chk("bp_rdy", in_ready, 0);
        end
        result("bp", 10000, 0, 0, 100, 0, 100, 3, 0);
        chk("bp_next_rdy", in_ready, 1);
        put(0, 0, 0); put(10, 10, 0); put(20, 20, 1);
        result("col", 0, 0, 0, 20, 0, 20, 3, 0);

        put(1, 2, 0); put(3, 4, 0);
        @(negedge clk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdy", in_ready, 0);
        chk("mid_rst_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        put(300, 40, 1);
        result("one", 0, 0, 300, 300, 40, 40, 1, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
